pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Multicycle control FSM that sequences each RV32I instruction through FETCH/DECODE/EXEC/MEM/WB.
- Decides when, and to which source, the program-counter register updates by driving its 2-bit stall_op and a next-PC mux select.
- Also issues instruction- and data-memory request strobes, and register-file and IR write enables.
- Sits between the instruction decoder, the memory interface and the PC/next-PC datapath.

Parameters:
- TIMEOUT, 15: max cycles to wait for imem_ready or dmem_ready before raising a bus-timeout trap (1..255).
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- opcode  input  7  instr[6:0] from the IR, valid from DECODE onward.
- branch_taken  input  1  branch comparator result, valid in EXEC.
- imem_ready  input  1  instruction memory data valid.
- dmem_ready  input  1  data memory access complete.
- replay  input  1  request to re-execute the previously committed instruction.
- stall_op  output  2  PC control: 0 = load next PC, 1 = restore previous PC, 2 = hold.
- next_pc_sel  output  2  0 = pc+4, 1 = pc+imm (branch/JAL), 2 = rs1+imm (JALR), 3 = trap vector.
- imem_req  output  1  instruction fetch request.
- dmem_req  output  1  data memory request.
- dmem_we  output  1  store strobe, qualifies dmem_req.
- ir_we  output  1  latch instruction register.
- rf_we  output  1  register-file write enable.
- trap  output  1  one-cycle pulse on illegal opcode or timeout.
- state  output  3  current FSM state, for debug.

Behaviour:
- State encodings: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=5, REPLAY=6.
- Reset (asynchronous, active-low): state=FETCH, wait counter=0. All outputs 0 except stall_op=2 and next_pc_sel=0.
- Outputs are Moore-style decodes of the registered state, plus opcode/branch_taken where noted. No combinational path from imem_ready/dmem_ready to stall_op.
- Default in every state: stall_op=2. stall_op=0 is asserted for exactly one cycle per committed instruction. stall_op=3 is never driven.

FETCH
- imem_req=1; the counter increments each cycle.
- imem_ready=1: ir_we=1, go to DECODE, clear the counter.
- Counter reaches TIMEOUT: go to TRAP.
- replay=1 in FETCH takes priority over imem_ready: go to REPLAY.

DECODE
- Always one cycle.
- Legal opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111, 1110011.
- Legal opcode: go to EXEC. Any other opcode: go to TRAP.

EXEC
- One cycle.
- LOAD (0000011) or STORE (0100011): go to MEM. All others: go to WB.

MEM
- dmem_req=1; dmem_we=1 when opcode is STORE.
- Hold until dmem_ready, then go to WB and clear the counter.
- Timeout: go to TRAP.

WB (commit)
- stall_op=0.
- rf_we=1 except for STORE and BRANCH.
- next_pc_sel:
  - 1 for JAL, or for BRANCH with branch_taken latched in EXEC.
  - 2 for JALR.
  - 0 otherwise.
- Then go to FETCH.

TRAP
- One cycle: trap=1, stall_op=0, next_pc_sel=3, rf_we=0. Then go to FETCH.

REPLAY
- One cycle: stall_op=1, so the PC restores its previous address. Then go to FETCH.
- replay is ignored in every state except FETCH.

Additional rules:
- branch_taken is registered at the end of EXEC so WB does not depend on comparator timing.
- Counter saturates; it is cleared on every state change.
- Reset asserted mid-instruction aborts it immediately:
  - no commit pulse;
  - in-flight memory requests are dropped (imem_req/dmem_req fall asynchronously).

Decomposition:
- Shared package: opcode constants (OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, etc.), the stall_op encodings (STALL_LOAD=0, STALL_RESTORE=1, STALL_HOLD=2), next_pc_sel encodings, and the state enum.
- One natural sub-module: mem_wait_timer, holding the counter, clear and timeout compare. It is shared by FETCH and MEM.

Test Plan:
- ADD (0110011), imem_ready on the 1st FETCH cycle -> states 0,1,2,4,0. stall_op=0 only in WB, with next_pc_sel=0 and rf_we=1. Total 4 cycles.
- LW (0000011), dmem_ready after 3 cycles -> MEM held 3 cycles with dmem_req=1 and dmem_we=0. WB rf_we=1. Total 7 cycles.
- BEQ (1100011) with branch_taken=1, then a repeat with branch_taken=0 -> WB next_pc_sel=1 and rf_we=0 in the first case; next_pc_sel=0 in the second.
- Opcode 0000000 -> DECODE then TRAP. trap pulses 1 cycle with stall_op=0 and next_pc_sel=3. Next state FETCH.
- imem_ready held low -> after TIMEOUT=15 FETCH cycles, TRAP for 1 cycle. Counter reads 0 on re-entry to FETCH.
- replay=1 together with imem_ready=1 in FETCH -> REPLAY with stall_op=1 for one cycle, ir_we=0. Async reset pulsed during MEM -> state=0 and stall_op=2 immediately, with no WB.

Source files
------------

// File: rtl/pc_sequencer_pkg.sv
// Shared encodings for the multicycle PC sequencer: opcodes, PC-control codes,
// next-PC mux selects and the FSM state type.
package pc_sequencer_pkg;

  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [1:0] {
    STALL_LOAD    = 2'd0,
    STALL_RESTORE = 2'd1,
    STALL_HOLD    = 2'd2
  } stall_op_e;

  typedef enum logic [1:0] {
    NPC_PLUS4  = 2'd0,
    NPC_PC_IMM = 2'd1,
    NPC_RS1    = 2'd2,
    NPC_TRAP   = 2'd3
  } next_pc_sel_e;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5,
    ST_REPLAY = 3'd6
  } state_e;

  function automatic logic is_legal_opcode(input logic [6:0] op);
    logic legal;
    legal = 1'b0;
    case (op)
      OP_OP, OP_OPIMM, OP_LOAD, OP_STORE, OP_BRANCH,
      OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/pc_sequencer_mem_wait_timer.sv
// Saturating wait counter shared by the FETCH and MEM states; flags a bus
// timeout once TIMEOUT consecutive cycles have been spent waiting.
module mem_wait_timer #(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clear_i,
  output logic timeout_o
);

  // The count reflects cycles already waited, so the TIMEOUT-th cycle sees TIMEOUT-1.
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_o = en_i && (cnt_q >= LIMIT);

endmodule

// File: rtl/pc_sequencer.sv
// Multicycle RV32I control FSM: steps each instruction through
// FETCH/DECODE/EXEC/MEM/WB and drives PC control, memory strobes and write enables.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned TIMEOUT = 15,
  parameter int unsigned CNT_W   = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [6:0] opcode_i,
  input  logic       branch_taken_i,
  input  logic       imem_ready_i,
  input  logic       dmem_ready_i,
  input  logic       replay_i,
  output logic [1:0] stall_op_o,
  output logic [1:0] next_pc_sel_o,
  output logic       imem_req_o,
  output logic       dmem_req_o,
  output logic       dmem_we_o,
  output logic       ir_we_o,
  output logic       rf_we_o,
  output logic       trap_o,
  output logic [2:0] state_o
);

  state_e       state_q, state_d;
  logic         taken_q, taken_d;
  stall_op_e    stall_op;
  next_pc_sel_e next_pc_sel;
  logic         timer_en, timer_clear, timeout;
  logic         is_store, is_branch;

  assign is_store  = (opcode_i == OP_STORE);
  assign is_branch = (opcode_i == OP_BRANCH);

  assign timer_en    = (state_q == ST_FETCH) || (state_q == ST_MEM);
  assign timer_clear = (state_d != state_q);

  mem_wait_timer #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_timer (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .en_i      (timer_en),
    .clear_i   (timer_clear),
    .timeout_o (timeout)
  );

  // WB uses the comparator result captured in EXEC, not the live input.
  assign taken_d = (state_q == ST_EXEC) ? branch_taken_i : taken_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_FETCH;
      taken_q <= 1'b0;
    end else begin
      state_q <= state_d;
      taken_q <= taken_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    stall_op    = STALL_HOLD;
    next_pc_sel = NPC_PLUS4;
    imem_req_o  = 1'b0;
    dmem_req_o  = 1'b0;
    dmem_we_o   = 1'b0;
    ir_we_o     = 1'b0;
    rf_we_o     = 1'b0;
    trap_o      = 1'b0;

    case (state_q)
      ST_FETCH: begin
        imem_req_o = 1'b1;
        if (replay_i) begin
          state_d = ST_REPLAY;
        end else if (imem_ready_i) begin
          ir_we_o = 1'b1;
          state_d = ST_DECODE;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_DECODE: state_d = is_legal_opcode(opcode_i) ? ST_EXEC : ST_TRAP;
      ST_EXEC: begin
        state_d = ((opcode_i == OP_LOAD) || is_store) ? ST_MEM : ST_WB;
      end
      ST_MEM: begin
        dmem_req_o = 1'b1;
        dmem_we_o  = is_store;
        if (dmem_ready_i) begin
          state_d = ST_WB;
        end else if (timeout) begin
          state_d = ST_TRAP;
        end
      end
      ST_WB: begin
        stall_op = STALL_LOAD;
        rf_we_o  = !(is_store || is_branch);
        if ((opcode_i == OP_JAL) || (is_branch && taken_q)) begin
          next_pc_sel = NPC_PC_IMM;
        end else if (opcode_i == OP_JALR) begin
          next_pc_sel = NPC_RS1;
        end
        state_d = ST_FETCH;
      end
      ST_TRAP: begin
        trap_o      = 1'b1;
        stall_op    = STALL_LOAD;
        next_pc_sel = NPC_TRAP;
        state_d     = ST_FETCH;
      end
      ST_REPLAY: begin
        stall_op = STALL_RESTORE;
        state_d  = ST_FETCH;
      end
      default: state_d = ST_FETCH;
    endcase

    // Reset drops requests and enables at once rather than at the next edge.
    if (!rst_ni) begin
      stall_op    = STALL_HOLD;
      next_pc_sel = NPC_PLUS4;
      imem_req_o  = 1'b0;
      dmem_req_o  = 1'b0;
      dmem_we_o   = 1'b0;
      ir_we_o     = 1'b0;
      rf_we_o     = 1'b0;
      trap_o      = 1'b0;
    end
  end

  assign stall_op_o    = stall_op;
  assign next_pc_sel_o = next_pc_sel;
  assign state_o       = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: walks instruction classes, traps, timeouts,
// replay and mid-instruction reset, checking every output each cycle.
module tb_pc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] opcode;
  logic       branch_taken, imem_ready, dmem_ready, replay;
  logic [1:0] stall_op, next_pc_sel;
  logic       imem_req, dmem_req, dmem_we, ir_we, rf_we, trap;
  logic [2:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  // flag order: {imem_req, ir_we, dmem_req, dmem_we, rf_we, trap}
  localparam logic [5:0] F_NONE  = 6'b000000;
  localparam logic [5:0] F_FETCH = 6'b100000;
  localparam logic [5:0] F_IR    = 6'b110000;
  localparam logic [5:0] F_RD    = 6'b001000;
  localparam logic [5:0] F_WR    = 6'b001100;
  localparam logic [5:0] F_RF    = 6'b000010;
  localparam logic [5:0] F_TRAP  = 6'b000001;

  pc_sequencer #(.TIMEOUT(15), .CNT_W(8)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .opcode_i       (opcode),
    .branch_taken_i (branch_taken),
    .imem_ready_i   (imem_ready),
    .dmem_ready_i   (dmem_ready),
    .replay_i       (replay),
    .stall_op_o     (stall_op),
    .next_pc_sel_o  (next_pc_sel),
    .imem_req_o     (imem_req),
    .dmem_req_o     (dmem_req),
    .dmem_we_o      (dmem_we),
    .ir_we_o        (ir_we),
    .rf_we_o        (rf_we),
    .trap_o         (trap),
    .state_o        (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got st/so/sel/flags=%b required=%b", tag, got, exp);
    else
      n_pass++;
  endtask

  // Inputs for this cycle are already driven; sample 1ns later, then move to the next negedge.
  task automatic step(input string tag, input logic [2:0] st, input logic [1:0] so,
                      input logic [1:0] sel, input logic [5:0] fl);
    #1;
    check(tag, {state, stall_op, next_pc_sel, imem_req, ir_we, dmem_req, dmem_we, rf_we, trap},
          {st, so, sel, fl});
    @(negedge clk);
  endtask

  task automatic front(input string tag, input logic [6:0] op);
    opcode = op; imem_ready = 1'b1;
    step({tag, ".fetch"}, 3'd0, 2'd2, 2'd0, F_IR);
    imem_ready = 1'b0;
    step({tag, ".decode"}, 3'd1, 2'd2, 2'd0, F_NONE);
  endtask

  initial begin
    rst_n = 1'b0; opcode = '0; branch_taken = 1'b0;
    imem_ready = 1'b0; dmem_ready = 1'b0; replay = 1'b0;
    @(negedge clk);
    step("reset", 3'd0, 2'd2, 2'd0, F_NONE);
    rst_n = 1'b1;

    front("add", 7'b0110011);
    step("add.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    step("add.wb", 3'd4, 2'd0, 2'd0, F_RF);
    $display("txn ADD done");

    front("lw", 7'b0000011);
    step("lw.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    step("lw.mem1", 3'd3, 2'd2, 2'd0, F_RD);
    step("lw.mem2", 3'd3, 2'd2, 2'd0, F_RD);
    dmem_ready = 1'b1;
    step("lw.mem3", 3'd3, 2'd2, 2'd0, F_RD);
    dmem_ready = 1'b0;
    step("lw.wb", 3'd4, 2'd0, 2'd0, F_RF);
    $display("txn LW done");

    front("sw", 7'b0100011);
    step("sw.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    dmem_ready = 1'b1;
    step("sw.mem", 3'd3, 2'd2, 2'd0, F_WR);
    dmem_ready = 1'b0;
    step("sw.wb", 3'd4, 2'd0, 2'd0, F_NONE);
    $display("txn SW done");

    front("beq_t", 7'b1100011);
    branch_taken = 1'b1;
    step("beq_t.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    branch_taken = 1'b0;
    step("beq_t.wb", 3'd4, 2'd0, 2'd1, F_NONE);
    $display("txn BEQ taken done");

    front("beq_n", 7'b1100011);
    step("beq_n.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    branch_taken = 1'b1;  // late change must not reach WB
    step("beq_n.wb", 3'd4, 2'd0, 2'd0, F_NONE);
    branch_taken = 1'b0;
    $display("txn BEQ not-taken done");

    front("jal", 7'b1101111);
    step("jal.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    step("jal.wb", 3'd4, 2'd0, 2'd1, F_RF);
    front("jalr", 7'b1100111);
    step("jalr.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    step("jalr.wb", 3'd4, 2'd0, 2'd2, F_RF);
    $display("txn JAL/JALR done");

    front("ill", 7'b0000000);
    step("ill.trap", 3'd5, 2'd0, 2'd3, F_TRAP);
    $display("txn illegal opcode done");

    // Two back-to-back fetch timeouts prove the counter restarts from zero.
    for (int r = 0; r < 2; r++) begin
      imem_ready = 1'b0;
      for (int i = 0; i < 15; i++) step("to.fetch", 3'd0, 2'd2, 2'd0, F_FETCH);
      step("to.trap", 3'd5, 2'd0, 2'd3, F_TRAP);
      $display("txn fetch timeout %0d done", r);
    end

    front("lw_to", 7'b0000011);
    step("lw_to.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    for (int i = 0; i < 15; i++) step("lw_to.mem", 3'd3, 2'd2, 2'd0, F_RD);
    step("lw_to.trap", 3'd5, 2'd0, 2'd3, F_TRAP);
    $display("txn data timeout done");

    opcode = 7'b0110011; imem_ready = 1'b1; replay = 1'b1;
    step("rp.fetch", 3'd0, 2'd2, 2'd0, F_FETCH);
    imem_ready = 1'b0;
    step("rp.replay", 3'd6, 2'd1, 2'd0, F_NONE);
    replay = 1'b0;
    step("rp.back", 3'd0, 2'd2, 2'd0, F_FETCH);
    $display("txn replay done");

    front("rst", 7'b0000011);
    step("rst.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    step("rst.mem", 3'd3, 2'd2, 2'd0, F_RD);
    rst_n = 1'b0;
    step("rst.async", 3'd0, 2'd2, 2'd0, F_NONE);
    dmem_ready = 1'b1;
    step("rst.held", 3'd0, 2'd2, 2'd0, F_NONE);
    dmem_ready = 1'b0; rst_n = 1'b1;
    front("rst_add", 7'b0110011);
    step("rst_add.exec", 3'd2, 2'd2, 2'd0, F_NONE);
    step("rst_add.wb", 3'd4, 2'd0, 2'd0, F_RF);
    $display("txn reset during MEM done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
